assoc_cache_miss_ctrl: RTL
==========================

// Module: assoc_cache_miss_ctrl
// PURPOSE
//  Parametrised tag/control engine for the split I/D caches: keeps valid, tag and LRU state
//  for two 2-way set-associative caches, reports hits and way selects, and runs one shared
//  miss-fill / write-through FSM against a word-wide memory handshake.
//  The data arrays sit outside this block and are driven by its hit-way and fill strobes.
//  Adds configurable geometry, true LRU victim choice, D-over-I arbitration and
//  hit-under-miss to the fixed 2-way controller.
// PARAMETERS
//  ADDR_W    16  byte address width
//  WORD_W    16  data word width (bytes = WORD_W/8)
//  SET_BITS  6   log2(sets per cache)
//  OFF_BITS  4   log2(block bytes); WORDS = 2**OFF_BITS/(WORD_W/8), default 8
//  TAG_W     derived: ADDR_W-SET_BITS-OFF_BITS (6)
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  i_req       in   1        instruction fetch request
//  i_addr      in   ADDR_W   fetch address
//  d_req       in   1        data access request
//  d_we        in   1        1 = store, 0 = load (valid with d_req)
//  d_addr      in   ADDR_W   data address
//  i_hit       out  1        fetch hits; i_way gives way
//  i_way       out  1        hitting way (I)
//  d_hit       out  1        data address hits; d_way gives way
//  d_way       out  1        hitting way (D)
//  i_stall     out  1        fetch must hold
//  d_stall     out  1        data access must hold
//  fill_we     out  1        write one fill word into the data array
//  fill_dcache out  1        fill target: 1 = D array, 0 = I array
//  fill_way    out  1        fill way
//  fill_set    out  SET_BITS fill set index
//  fill_word   out  OFF_BITS-log2(WORD_W/8)  fill word index
//  mem_req     out  1        memory request, held until mem_ready
//  mem_we      out  1        1 = write-through store, 0 = fill read
//  mem_addr    out  ADDR_W   word-aligned memory address
//  mem_ready   in   1        read word valid on memory data bus / write accepted
// BEHAVIOUR
//  Reset: all valid bits 0, LRU bits 0, FSM IDLE, word counter 0.
//   All outputs 0; hits and stalls follow from the cleared state.
//  Lookup: set = addr[OFF_BITS+:SET_BITS], tag = addr[ADDR_W-1-:TAG_W].
//   Hit = valid & tag match on either way; combinational.
//   Both ports are looked up every cycle, in any FSM state (hit-under-miss).
//  LRU: one bit per set, naming the way to replace next.
//   Read hit (I or D) sets LRU to the other way.
//   Victim: first invalid way (way0 before way1), else the LRU way.
//  i_stall = i_req & ~i_hit.
//  d_stall = d_req & ~(d_hit & ~d_we) & ~(state==WRITE & mem_ready).
//  IDLE: arbitration priority, highest first:
//   1. D store -> WRITE.
//   2. D load miss -> FILL (D).
//   3. I miss -> FILL (I).
//   On entering FILL:
//   - latch the target cache, set and tag;
//   - clear the victim's valid bit the same edge, so partial data is never a hit;
//   - counter = 0.
//  FILL:
//   - mem_req=1, mem_we=0, mem_addr={tag,set,cnt,0s}.
//   - Each cycle mem_ready=1: fill_we=1 for that word and cnt++.
//   - mem_ready=0: hold everything.
//   - After word WORDS-1 is accepted -> TAG.
//  TAG (1 cycle):
//   - write tag, valid=1, LRU = other way;
//   - -> IDLE; the requester hits the next cycle.
//  WRITE (write-through, no-allocate):
//   - mem_req=1, mem_we=1, mem_addr=d_addr;
//   - on mem_ready -> IDLE.
//   - In the mem_ready cycle d_stall=0; if d_hit, the datapath writes its data array using d_way.
//   - A store never changes valid or LRU.
//  Miss latency with mem_ready tied 1: 1 + WORDS + 1 cycles of stall (10 by default).
//  Requests arriving while not IDLE wait; a request dropped before service is not served.
//  An async reset mid-FILL or mid-WRITE aborts at once: mem_req=0, and all state reset.
// TESTING
//  1. Reset, i_req=1, i_addr=0x1234, mem_ready=1:
//     mem_addr 0x1230,0x1232..0x123E with fill_we x8 (fill_word 0..7, fill_set 0x23);
//     i_hit=1 and i_stall=0 on cycle 11.
//  2. Set 0x23, tag A into way0, then tag B into way1; read A; miss on tag C:
//     fill_way=1 (B evicted); A still hits.
//  3. I miss and D load miss in the same cycle: D fill completes first,
//     then I fill starts; d_stall drops 10 cycles before i_stall.
//  4. Store to a cached address: one mem_req with mem_we=1 at that address, no fill_we;
//     d_stall=1 until the mem_ready cycle; d_hit stays 1.
//  5. Fill with mem_ready low for 5 cycles after word 3:
//     mem_addr and fill_word hold, no fill_we; fill resumes at word 4.
//     Reset after word 5: mem_req=0 next, all hits 0.
//  6. During a D fill, I fetch of a resident line: i_hit=1, i_stall=0 throughout.

Source files
------------

// File: rtl/assoc_cache_miss_ctrl.sv
// Tag, valid and LRU state for split 2-way I/D caches.
// One shared miss-fill / write-through FSM with D-over-I arbitration.
module assoc_cache_miss_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int WORD_W   = 16,
  parameter int SET_BITS = 6,
  parameter int OFF_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_W-1:0]         d_addr,
  output logic                      i_hit,
  output logic                      i_way,
  output logic                      d_hit,
  output logic                      d_way,
  output logic                      i_stall,
  output logic                      d_stall,
  output logic                      fill_we,
  output logic                      fill_dcache,
  output logic                      fill_way,
  output logic [SET_BITS-1:0]       fill_set,
  output logic [OFF_BITS-$clog2(WORD_W/8)-1:0] fill_word,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready
);

  localparam int TAG_W = ADDR_W - SET_BITS - OFF_BITS;
  localparam int BB    = $clog2(WORD_W / 8);
  localparam int WB    = OFF_BITS - BB;
  localparam int SETS  = 1 << SET_BITS;
  localparam logic [WB-1:0]     LAST  = '1;
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << BB) - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG, WRITE} state_e;

  state_e                  state_q;
  logic [WB-1:0]           cnt_q;
  logic                    tgt_q;
  logic                    way_q;
  logic [SET_BITS-1:0]     set_q;
  logic [TAG_W-1:0]        tagl_q;
  // [cache][way][set], cache 1 = D
  logic [1:0][1:0][SETS-1:0] vld_q;
  logic [1:0][SETS-1:0]      lru_q;
  logic [TAG_W-1:0]          tag_q [2][2][SETS];

  logic [SET_BITS-1:0] i_set, d_set, v_set;
  logic [TAG_W-1:0]    i_tag, d_tag, v_tag;
  logic i_h0, i_h1, d_h0, d_h1;
  logic i_miss, d_ld_miss, tgt_d, v_way;
  logic unused_off;

  assign i_set = i_addr[OFF_BITS +: SET_BITS];
  assign d_set = d_addr[OFF_BITS +: SET_BITS];
  assign i_tag = i_addr[ADDR_W-1 -: TAG_W];
  assign d_tag = d_addr[ADDR_W-1 -: TAG_W];
  assign unused_off = ^i_addr[OFF_BITS-1:0];

  assign i_h0 = vld_q[0][0][i_set] && (tag_q[0][0][i_set] == i_tag);
  assign i_h1 = vld_q[0][1][i_set] && (tag_q[0][1][i_set] == i_tag);
  assign d_h0 = vld_q[1][0][d_set] && (tag_q[1][0][d_set] == d_tag);
  assign d_h1 = vld_q[1][1][d_set] && (tag_q[1][1][d_set] == d_tag);

  assign i_hit = i_h0 | i_h1;
  assign i_way = i_h1;
  assign d_hit = d_h0 | d_h1;
  assign d_way = d_h1;

  assign i_stall = i_req & ~i_hit;
  assign d_stall = d_req & ~(d_hit & ~d_we)
                 & ~((state_q == WRITE) & mem_ready);

  assign i_miss    = i_req & ~i_hit;
  assign d_ld_miss = d_req & ~d_we & ~d_hit;
  assign tgt_d     = d_ld_miss;
  assign v_set     = tgt_d ? d_set : i_set;
  assign v_tag     = tgt_d ? d_tag : i_tag;

  // Invalid ways are consumed before the LRU way
  assign v_way = !vld_q[tgt_d][0][v_set] ? 1'b0 :
                 !vld_q[tgt_d][1][v_set] ? 1'b1 :
                 lru_q[tgt_d][v_set];

  assign fill_we     = (state_q == FILL) & mem_ready;
  assign fill_dcache = tgt_q;
  assign fill_way    = way_q;
  assign fill_set    = set_q;
  assign fill_word   = cnt_q;
  assign mem_req     = (state_q == FILL) | (state_q == WRITE);
  assign mem_we      = (state_q == WRITE);

  always_comb begin
    mem_addr = '0;
    if (state_q == FILL)
      mem_addr = ADDR_W'({tagl_q, set_q, cnt_q}) << BB;
    else if (state_q == WRITE)
      mem_addr = d_addr & ~AMASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      way_q   <= 1'b0;
      set_q   <= '0;
      tagl_q  <= '0;
      vld_q   <= '0;
      lru_q   <= '0;
    end else begin
      if (i_req && i_hit)
        lru_q[0][i_set] <= ~i_way;
      if (d_req && !d_we && d_hit)
        lru_q[1][d_set] <= ~d_way;
      unique case (state_q)
        IDLE: begin
          if (d_req && d_we) begin
            state_q <= WRITE;
          end else if (d_ld_miss || i_miss) begin
            state_q <= FILL;
            tgt_q   <= tgt_d;
            set_q   <= v_set;
            tagl_q  <= v_tag;
            way_q   <= v_way;
            cnt_q   <= '0;
            vld_q[tgt_d][v_way][v_set] <= 1'b0;
          end
        end
        FILL: begin
          if (mem_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST)
              state_q <= TAG;
          end
        end
        TAG: begin
          vld_q[tgt_q][way_q][set_q] <= 1'b1;
          lru_q[tgt_q][set_q]        <= ~way_q;
          state_q                    <= IDLE;
        end
        WRITE: begin
          if (mem_ready)
            state_q <= IDLE;
        end
      endcase
    end
  end

  // Tags are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (state_q == TAG)
      tag_q[tgt_q][way_q][set_q] <= tagl_q;
  end

endmodule
